// File: rtl/mac_lane_accumulator.sv
// Multi-lane signed fixed-point MAC: per-lane products, lane sum rescaled by FRAC_BITS,
// framed accumulation with saturate/wrap and a sticky overflow flag, one result per frame.
module mac_lane_accumulator #(
    parameter int DATA_W    = 16,
    parameter int ACC_W     = 32,
    parameter int FRAC_BITS = 8,
    parameter int LANES     = 4,
    parameter int SAT_EN    = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic                    in_first,
    input  logic                    in_last,
    input  logic [LANES-1:0]        lane_en,
    input  logic [LANES*DATA_W-1:0] a,
    input  logic [LANES*DATA_W-1:0] b,
    output logic                    out_valid,
    output logic [ACC_W-1:0]        out_data,
    output logic                    out_sat
);

    localparam int PROD_W  = 2 * DATA_W;
    localparam int SUM_W   = PROD_W + $clog2(LANES);
    localparam int SHIFT_W = SUM_W - FRAC_BITS;
    // Term is at least ACC_W+1 wide; widened further if the rescaled sum could not fit.
    localparam int TERM_W  = (SHIFT_W > ACC_W + 1) ? SHIFT_W : ACC_W + 1;
    localparam int NXT_W   = TERM_W + 1;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // Stage 1: per-lane products
    logic signed [PROD_W-1:0] prod_next [LANES];
    logic signed [PROD_W-1:0] prod_reg  [LANES];
    logic                     s1_valid_reg, s1_first_reg, s1_last_reg;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic signed [DATA_W-1:0] a_lane;
            logic signed [DATA_W-1:0] b_lane;
            assign a_lane        = a[gi*DATA_W +: DATA_W];
            assign b_lane        = b[gi*DATA_W +: DATA_W];
            assign prod_next[gi] = lane_en[gi] ? PROD_W'(a_lane) * PROD_W'(b_lane) : '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LANES; i++) prod_reg[i] <= '0;
            s1_valid_reg <= 1'b0;
            s1_first_reg <= 1'b0;
            s1_last_reg  <= 1'b0;
        end else begin
            for (int i = 0; i < LANES; i++) prod_reg[i] <= prod_next[i];
            s1_valid_reg <= in_valid;
            s1_first_reg <= in_valid & in_first;
            s1_last_reg  <= in_valid & in_last;
        end
    end

    // Stage 2: lane sum and Q-format rescale (floor via arithmetic shift)
    logic signed [SUM_W-1:0]  sum_next;
    logic signed [TERM_W-1:0] term_next;
    logic signed [TERM_W-1:0] term_reg;
    logic                     s2_valid_reg, s2_first_reg, s2_last_reg;

    always_comb begin
        sum_next = '0;
        for (int i = 0; i < LANES; i++) sum_next = sum_next + SUM_W'(prod_reg[i]);
        term_next = TERM_W'(sum_next >>> FRAC_BITS);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            term_reg     <= '0;
            s2_valid_reg <= 1'b0;
            s2_first_reg <= 1'b0;
            s2_last_reg  <= 1'b0;
        end else begin
            term_reg     <= term_next;
            s2_valid_reg <= s1_valid_reg;
            s2_first_reg <= s1_first_reg;
            s2_last_reg  <= s1_last_reg;
        end
    end

    // Stage 3: accumulate with range check
    logic signed [ACC_W-1:0] acc_reg, acc_next;
    logic                    sticky_reg, sticky_next;
    logic                    emit_reg;
    logic signed [NXT_W-1:0] base, nxt;
    logic                    ovf_hi, ovf_lo;

    always_comb begin
        base   = s2_first_reg ? '0 : NXT_W'(acc_reg);
        nxt    = base + NXT_W'(term_reg);
        ovf_hi = nxt > NXT_W'(ACC_MAX);
        ovf_lo = nxt < NXT_W'(ACC_MIN);
        acc_next = nxt[ACC_W-1:0];
        if (SAT_EN != 0) begin
            if (ovf_hi)      acc_next = ACC_MAX;
            else if (ovf_lo) acc_next = ACC_MIN;
        end
        sticky_next = (s2_first_reg ? 1'b0 : sticky_reg) | ovf_hi | ovf_lo;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_reg    <= '0;
            sticky_reg <= 1'b0;
            emit_reg   <= 1'b0;
        end else begin
            if (s2_valid_reg) begin
                acc_reg    <= acc_next;
                sticky_reg <= sticky_next;
            end
            emit_reg <= s2_valid_reg & s2_last_reg;
        end
    end

    // Output register: pulse on frame end, data/flag held between frames
    logic                out_valid_reg;
    logic [ACC_W-1:0]    out_data_reg;
    logic                out_sat_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_sat_reg   <= 1'b0;
        end else begin
            out_valid_reg <= emit_reg;
            if (emit_reg) begin
                out_data_reg <= acc_reg;
                out_sat_reg  <= sticky_reg;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_sat   = out_sat_reg;

endmodule

// File: doc/mac_lane_accumulator.md
Name: mac_lane_accumulator

Overview:
- Parametrised multi-lane, fixed-point multiply-accumulate engine: the next-generation MAC for the accelerator cores.
- Each beat multiplies LANES signed operand pairs, sums the products, and rescales the sum by FRAC_BITS.
- Accumulates the rescaled sums over a framed sequence of beats (first/last markers), with selectable saturate or wrap.
- Emits one valid-tagged result per frame; the result feeds the core's output buffer.

Parameters:
- DATA_W, 16, signed operand width per lane
- ACC_W, 32, signed accumulator/result width
- FRAC_BITS, 8, arithmetic right shift applied to the per-beat lane sum (Q-format rescale)
- LANES, 4, number of parallel multiplier lanes (1..16)
- SAT_EN, 1, 1 = saturate accumulator to ACC_W range, 0 = two's-complement wrap

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; synchronous, active-low
- in_valid  in  1  beat qualifier; no backpressure, one beat accepted per cycle when high
- in_first  in  1  beat starts a new frame (accumulator loads instead of adds); ignored when in_valid=0
- in_last  in  1  beat ends a frame (result emitted); ignored when in_valid=0
- lane_en  in  LANES  per-lane enable; a disabled lane contributes 0
- a  in  LANES*DATA_W  packed signed operands, lane i at [i*DATA_W +: DATA_W]
- b  in  LANES*DATA_W  packed signed operands, same packing
- out_valid  out  1  one-cycle pulse, result available
- out_data  out  ACC_W  signed frame result; held until next out_valid
- out_sat  out  1  frame saturated (SAT_EN=1) or overflowed (SAT_EN=0) at least once; held with out_data

Behaviour:
- Reset: rst_n=0 at an edge clears all pipeline registers, valid/first/last tags, accumulator and sticky flag. Sets out_valid=0, out_data=0, out_sat=0. In-flight beats are discarded. The first frame after reset needs in_first.
- Stage 1 (edge E, beat sampled): per lane, product = a_i*b_i, full 2*DATA_W signed, or 0 if lane_en[i]=0. valid/first/last tags registered alongside.
- Stage 2 (E+1):
  - sum = signed sum of all lane products, width 2*DATA_W+clog2(LANES), no overflow possible.
  - term = sum >>> FRAC_BITS, arithmetic shift with truncation toward minus infinity.
  - term is sign-extended to ACC_W+1 bits.
- Stage 3 (E+2), tagged valid only:
  - nxt = (first ? 0 : acc) + term, computed in ACC_W+1 bits.
  - If nxt exceeds the ACC_W signed range:
    - SAT_EN=1: clamp to 2^(ACC_W-1)-1 or -2^(ACC_W-1), and set the sticky flag.
    - SAT_EN=0: keep the low ACC_W bits, and set the sticky flag.
  - first clears the sticky flag before this beat's update.
  - Once saturated, further terms still add to the clamped value; there is no latch-at-rail.
  - Untagged (bubble) cycles leave acc and the sticky flag unchanged.
- Output (E+3): if the stage-3 beat carried last, set out_valid=1 for exactly one cycle, out_data = updated acc, out_sat = updated sticky flag. Otherwise out_valid=0 and out_data/out_sat hold.
- Latency: beat with in_last sampled at edge E gives out_valid high in the cycle after edge E+3.
- Throughput: one beat per cycle, with back-to-back frames. Last of frame k and first of frame k+1 on consecutive cycles must produce correct independent results.
- in_first=1 and in_last=1 on the same beat: single-beat frame, result = saturated/wrapped term.
- A beat without in_first after a completed frame continues accumulating onto the previous result. This is legal and is used for running sums.
- in_first asserted mid-frame abandons the old frame: no output for it.
- in_valid=0 between beats of a frame is allowed; gaps of any length.

Test Plan:
- Defaults, all lanes enabled, a=0x0100, b=0x0200 on each lane. Three beats first/-/last, contiguous -> single out_valid 3 cycles after the last beat, out_data=0x00001800, out_sat=0.
- lane_en=4'b0001, a0=0x0001, b0=0xFFFF, single first+last beat -> out_data=0xFFFFFFFF (-1, truncation toward minus infinity), out_sat=0.
- ACC_W=24, SAT_EN=1, all lanes a=b=0x7FFF, first+last -> out_data=0x7FFFFF, out_sat=1. Then all lanes a=0x8000, b=0x7FFF -> out_data=0x800000, out_sat=1.
- ACC_W=24, SAT_EN=0, all lanes a=b=0x7FFF, first+last -> out_data=0xFFFC00 (wrapped), out_sat=1.
- Back-to-back frames with 2 bubble cycles inside frame 1:
  - frame 1 = 2 beats of the first scenario's stimulus -> out_data=0x00001000;
  - frame 2 starts the very next cycle after frame 1's last, one beat of lane0-only 0x0100*0x0100 -> out_data=0x00000100;
  - both have out_sat=0, and the out_valid pulses are exactly the first beat-to-beat spacing apart.
- rst_n low for one cycle mid-frame, then a fresh first+last beat -> no out_valid for the aborted frame. Outputs read 0 the cycle after reset. The new frame's result is independent of pre-reset state.
